// File: rtl/multi_port_slow_mem.sv
// multi_port_slow_mem: one shared line memory serving NUM_PORTS requesters.
// Ports are arbitrated round-robin, and only one transaction is in flight at a time.
// Each access completes a fixed LATENCY cycles after its grant.
// Build option: define SLOWMEM_STAT_EN to get saturating read/write completion
// counters on stat_reads/stat_writes; otherwise both outputs are tied to zero.
module multi_port_slow_mem #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_BITS  = 128,
    parameter int ADDR_BITS  = 28,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           mem_read,
    input  logic [NUM_PORTS-1:0]           mem_write,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] mem_addr,
    input  logic [NUM_PORTS*LINE_BITS-1:0] mem_wdata,
    output logic [NUM_PORTS*LINE_BITS-1:0] mem_rdata,
    output logic [NUM_PORTS-1:0]           mem_ready,
    output logic [15:0]                    stat_reads,
    output logic [15:0]                    stat_writes
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PW1   = PTR_W + 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PTR_W:0]   NP_W     = PW1'(NUM_PORTS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      gnt_q, gnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [LINE_BITS-1:0]  wdata_q, wdata_d;
    logic                  grant_en, commit_en;

    // Arbitration signals: the request vector rotated so the pointer port sits at bit 0
    logic [NUM_PORTS-1:0]   req_w, rot_w, first_w;
    logic [2*NUM_PORTS-1:0] rot2_w;
    logic [PTR_W-1:0]       off_w, win_w, ptr_next_w;
    logic [PTR_W:0]         sum_w, wrap_w, nxt_w;
    logic                   req_any;
    logic [DEPTH_LOG2-1:0]  idx_arr   [NUM_PORTS];
    logic [LINE_BITS-1:0]   wdata_arr [NUM_PORTS];
    logic [LINE_BITS-1:0]   mem_q     [DEPTH];
    logic                   unused_bits;

    genvar gi, gb;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_req
            assign req_w[gi]     = mem_read[gi] | mem_write[gi];
            assign idx_arr[gi]   = mem_addr[gi*ADDR_BITS +: DEPTH_LOG2];
            assign wdata_arr[gi] = mem_wdata[gi*LINE_BITS +: LINE_BITS];
            if (gi == 0) begin : g_first
                assign first_w[gi] = rot_w[gi];
            end else begin : g_rest
                assign first_w[gi] = rot_w[gi] & ~(|rot_w[gi-1:0]);
            end
        end
        // Offset of the first requester in rotated order, one bit at a time
        for (gb = 0; gb < PTR_W; gb++) begin : g_off
            logic [NUM_PORTS-1:0] sel_mask;
            for (gi = 0; gi < NUM_PORTS; gi++) begin : g_m
                assign sel_mask[gi] = (((gi >> gb) % 2) == 1);
            end
            assign off_w[gb] = |(first_w & sel_mask);
        end
    endgenerate

    assign req_any    = |req_w;
    assign rot2_w     = {req_w, req_w} >> ptr_q;
    assign rot_w      = rot2_w[NUM_PORTS-1:0];
    assign sum_w      = {1'b0, ptr_q} + {1'b0, off_w};
    assign wrap_w     = (sum_w >= NP_W) ? (sum_w - NP_W) : sum_w;
    assign win_w      = wrap_w[PTR_W-1:0];
    assign nxt_w      = {1'b0, win_w} + PW1'(1);
    assign ptr_next_w = (nxt_w == NP_W) ? '0 : nxt_w[PTR_W-1:0];
    // High address bits alias away by design; fold them into a sink
    assign unused_bits = ^{mem_addr, rot2_w, wrap_w[PTR_W], nxt_w[PTR_W]};

    // State register plus captured transaction; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: IDLE -> BUSY on any request, BUSY -> DONE when count expires
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs: grant capture, latency countdown and commit strobe
    always_comb begin
        grant_en  = (state_q == IDLE) && req_any;
        commit_en = (state_q == BUSY) && (cnt_q == '0);
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        if (grant_en) begin
            ptr_d   = ptr_next_w;
            gnt_d   = win_w;
            wr_d    = mem_write[win_w];
            idx_d   = idx_arr[win_w];
            wdata_d = wdata_arr[win_w];
            cnt_d   = CNT_LOAD;
        end else if ((state_q == BUSY) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Line storage: written only on a committed write; contents survive reset
    always_ff @(posedge clk) begin
        if (commit_en && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
            logic                 ready_q;
            logic [LINE_BITS-1:0] rdata_q;
            // Per-port response: one-cycle ready pulse, read data held until next read
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end else begin
                    ready_q <= commit_en && (gnt_q == PTR_W'(gi));
                    if (commit_en && !wr_q && (gnt_q == PTR_W'(gi))) begin
                        rdata_q <= mem_q[idx_q];
                    end
                end
            end
            assign mem_ready[gi]                         = ready_q;
            assign mem_rdata[gi*LINE_BITS +: LINE_BITS] = rdata_q;
        end
    endgenerate

`ifdef SLOWMEM_STAT_EN
    logic [15:0] stat_reads_q, stat_writes_q;
    // Saturating completion counters, bumped on the commit edge so they update with ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else if (commit_en) begin
            if (wr_q) begin
                if (stat_writes_q != 16'hFFFF) stat_writes_q <= stat_writes_q + 16'd1;
            end else begin
                if (stat_reads_q != 16'hFFFF) stat_reads_q <= stat_reads_q + 16'd1;
            end
        end
    end
    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`else
    assign stat_reads  = 16'h0000;
    assign stat_writes = 16'h0000;
`endif

endmodule

// File: tb/tb_multi_port_slow_mem.sv
// Bench for multi_port_slow_mem: directed scenarios plus random multi-port traffic,
// checked against a transaction-level model (array memory, round-robin pointer,
// per-port last-read data and completion counts).
module tb_multi_port_slow_mem;
    localparam int NP  = 2;
    localparam int LB  = 128;
    localparam int AB  = 28;
    localparam int DL  = 10;
    localparam int LAT = 10;
`ifdef SLOWMEM_STAT_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    mem_read, mem_write, mem_ready;
    logic [NP*AB-1:0] mem_addr;
    logic [NP*LB-1:0] mem_wdata, mem_rdata;
    logic [15:0]      stat_reads, stat_writes;

    int total = 0;
    int bad   = 0;

    logic [LB-1:0] model_mem [int];
    logic [LB-1:0] model_rdata [NP];
    int            model_ptr;
    int            model_reads, model_writes;

    multi_port_slow_mem #(
        .NUM_PORTS(NP), .LINE_BITS(LB), .ADDR_BITS(AB), .DEPTH_LOG2(DL), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stat_reads(stat_reads), .stat_writes(stat_writes)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input bit rd, input bit wr,
                         input logic [AB-1:0] a, input logic [LB-1:0] d);
        mem_read[p]            = rd;
        mem_write[p]           = wr;
        mem_addr[p*AB +: AB]   = a;
        mem_wdata[p*LB +: LB]  = d;
    endtask

    task automatic check_stats();
        check("stat_reads",  stat_reads,  STAT_ON ? LB'(model_reads)  : '0);
        check("stat_writes", stat_writes, STAT_ON ? LB'(model_writes) : '0);
    endtask

    task automatic check_rdata();
        for (int p = 0; p < NP; p++)
            check($sformatf("rdata%0d", p), mem_rdata[p*LB +: LB], model_rdata[p]);
    endtask

    // Serve every pending request in model round-robin order; drop each request after its grant.
    task automatic serve_pending();
        int guard;
        int w, c, idx, n;
        bit is_wr, seen;
        logic [LB-1:0] wd;
        logic [NP-1:0] exp_rdy;
        guard = 0;
        while (((mem_read | mem_write) != '0) && guard < 16) begin
            guard++;
            w = -1;
            for (int k = 0; k < NP; k++) begin
                c = (model_ptr + k) % NP;
                if (w < 0 && (mem_read[c] || mem_write[c])) w = c;
            end
            is_wr = mem_write[w];
            idx   = int'(mem_addr[w*AB +: AB]) % (1 << DL);
            wd    = mem_wdata[w*LB +: LB];
            tick();                         // grant edge
            mem_read[w]  = 1'b0;
            mem_write[w] = 1'b0;
            model_ptr = (w + 1) % NP;
            n = 1;
            seen = 1'b0;
            while (!seen && n < 4*LAT) begin
                tick();
                n++;
                if (mem_ready != '0) seen = 1'b1;
            end
            check($sformatf("ready_latency_p%0d", w), LB'(n), LB'(LAT + 1));
            exp_rdy = '0;
            exp_rdy[w] = 1'b1;
            check("ready_port", mem_ready, exp_rdy);
            if (is_wr) begin
                model_mem[idx] = wd;
                if (model_writes < 65535) model_writes++;
            end else begin
                model_rdata[w] = model_mem[idx];
                if (model_reads < 65535) model_reads++;
            end
            tick();
            check("ready_width", mem_ready, '0);
            check_rdata();
            check_stats();
            $display("txn port=%0d op=%s idx=%0d latency=%0d", w, is_wr ? "WR" : "RD", idx, n);
        end
        check("serve_guard", LB'(guard < 16), LB'(1));
    endtask

    initial begin
        logic [AB-1:0] a;
        logic [LB-1:0] d;
        int mask, op;
        bit any_ready;

        mem_read = '0; mem_write = '0; mem_addr = '0; mem_wdata = '0;
        model_ptr = 0; model_reads = 0; model_writes = 0;
        for (int p = 0; p < NP; p++) model_rdata[p] = '0;
        rst = 1'b1;
        tick(); tick(); tick();
        check("reset_ready", mem_ready, '0);
        check_rdata();
        check_stats();
        rst = 1'b0;
        tick();

        // Simultaneous requests right after reset: port 0 first, port 1 twelve edges later
        drive(0, 1'b0, 1'b1, 28'h7, 128'hA0A0_0000_0000_0000_0000_0000_0000_0007);
        drive(1, 1'b0, 1'b1, 28'h8, 128'hB1B1_0000_0000_0000_0000_0000_0000_0008);
        serve_pending();
        drive(0, 1'b1, 1'b0, 28'h8, '0);
        drive(1, 1'b1, 1'b0, 28'h7, '0);
        serve_pending();

        // Write then read back at address 5 on port 0
        drive(0, 1'b0, 1'b1, 28'h5, 128'hDEADBEEF);
        serve_pending();
        drive(0, 1'b1, 1'b0, 28'h5, '0);
        serve_pending();

        // Aliasing: 0x405 maps to line 5
        drive(1, 1'b0, 1'b1, 28'h405, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        serve_pending();
        drive(1, 1'b1, 1'b0, 28'h5, '0);
        serve_pending();

        // Read and write together: write wins, port 0 read data stays put
        drive(0, 1'b1, 1'b1, 28'hFFF0005, 128'h5555);
        serve_pending();
        drive(0, 1'b1, 1'b0, 28'h5, '0);
        serve_pending();

        // Reset four cycles after a write grant aborts the write
        drive(0, 1'b0, 1'b1, 28'h21, 128'h0_1D);
        serve_pending();
        drive(0, 1'b0, 1'b1, 28'h21, 128'hBAD0_BAD0);
        tick();
        mem_write[0] = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_ready", mem_ready, '0);
        model_ptr = 0; model_reads = 0; model_writes = 0;
        for (int p = 0; p < NP; p++) model_rdata[p] = '0;
        check_rdata();
        check_stats();
        tick(); tick();
        rst = 1'b0;
        any_ready = 1'b0;
        for (int i = 0; i < 2*LAT; i++) begin
            tick();
            if (mem_ready != '0) any_ready = 1'b1;
        end
        check("abort_no_ready", LB'(any_ready), '0);
        drive(1, 1'b1, 1'b0, 28'h21, '0);
        serve_pending();
        check("abort_no_commit", mem_rdata[1*LB +: LB], 128'h0_1D);

        // Counter scenario: three reads, two writes since reset
        drive(0, 1'b0, 1'b1, 28'h30, 128'h30);
        drive(1, 1'b0, 1'b1, 28'h31, 128'h31);
        serve_pending();
        drive(0, 1'b1, 1'b0, 28'h31, '0);
        drive(1, 1'b1, 1'b0, 28'h30, '0);
        serve_pending();
        check("stat_reads_3",  stat_reads,  STAT_ON ? LB'(3) : '0);
        check("stat_writes_2", stat_writes, STAT_ON ? LB'(2) : '0);

        // Random traffic over an eight-line pool with random high address bits
        for (int k = 0; k < 8; k++) begin
            a = AB'($urandom);
            a[DL-1:0] = DL'(100 + k);
            d = {$urandom, $urandom, $urandom, $urandom};
            drive(k % NP, 1'b0, 1'b1, a, d);
            serve_pending();
        end
        for (int it = 0; it < 25; it++) begin
            mask = $urandom_range(1, (1 << NP) - 1);
            for (int p = 0; p < NP; p++) begin
                if (((mask >> p) & 1) == 1) begin
                    op = $urandom_range(0, 2);
                    a = AB'($urandom);
                    a[DL-1:0] = DL'(100 + $urandom_range(0, 7));
                    d = {$urandom, $urandom, $urandom, $urandom};
                    drive(p, op != 1, op != 0, a, d);
                end
            end
            serve_pending();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_port_slow_mem.md
MULTI_PORT_SLOW_MEM -- requirements
Module: multi_port_slow_mem

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2, meaning the number of independent requester channels (1..8).
REQ-002 The block SHALL have parameter LINE_BITS, default 128, meaning the data width per access.
REQ-003 The block SHALL have parameter ADDR_BITS, default 28, meaning the line-address width per port.
REQ-004 The block SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of stored lines, with DEPTH_LOG2 <= ADDR_BITS.
REQ-005 The block SHALL have parameter LATENCY, default 10, meaning the cycles from grant to response, with LATENCY >= 1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port mem_read, input, NUM_PORTS bits: per-port read request.
REQ-009 The block SHALL have port mem_write, input, NUM_PORTS bits: per-port write request.
REQ-010 The block SHALL have port mem_addr, input, NUM_PORTS*ADDR_BITS bits: per-port line address, with port p at slice [p*ADDR_BITS +: ADDR_BITS].
REQ-011 The block SHALL have port mem_wdata, input, NUM_PORTS*LINE_BITS bits: per-port write line.
REQ-012 The block SHALL have port mem_rdata, output, NUM_PORTS*LINE_BITS bits: per-port read line.
REQ-013 The block SHALL have port mem_ready, output, NUM_PORTS bits: per-port one-cycle completion pulse.
REQ-014 The block SHALL have port stat_reads, output, 16 bits: completed-read counter.
REQ-015 The block SHALL have port stat_writes, output, 16 bits: completed-write counter.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY and DONE, with one transaction in flight at a time.
REQ-017 In IDLE, at the first edge where any port has mem_read or mem_write high, the block SHALL grant one port, capture its address, wdata and operation, load the counter with LATENCY-1 and enter BUSY.
REQ-018 Arbitration SHALL be round-robin: the pointer is 0 after reset, the first requesting port at or after the pointer (mod NUM_PORTS) wins, and the pointer then becomes winner+1 mod NUM_PORTS.
REQ-019 In BUSY the counter SHALL decrement each edge; at the edge where the counter is 0 the block SHALL commit a write or load mem_rdata[granted] with a read, and enter DONE.
REQ-020 In DONE, mem_ready[granted] SHALL be high for exactly that one cycle, and the FSM SHALL return to IDLE unconditionally.
REQ-021 The response timing SHALL be: grant at edge E, mem_ready high during the cycle after edge E+LATENCY, and next grant no earlier than edge E+LATENCY+2.
REQ-022 If mem_read and mem_write are both high on the granted port, the block SHALL perform a write and SHALL NOT update rdata.
REQ-023 The memory index SHALL be addr[DEPTH_LOG2-1:0]; higher address bits SHALL be ignored, so addresses alias modulo 2^DEPTH_LOG2.
REQ-024 A captured transaction SHALL complete even if the requester deasserts its request during BUSY, and mem_ready SHALL still pulse.
REQ-025 mem_rdata[p] SHALL hold its value until port p's next completed read; writes and other ports' traffic SHALL NOT alter it.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While rst is high, the FSM SHALL be IDLE, the pointer 0, the counter 0, mem_ready all 0, mem_rdata all 0, and stat_reads and stat_writes 0.
REQ-028 Reset asserted mid-transaction SHALL abort it with no write commit and no ready pulse.
REQ-029 Stored memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With macro SLOWMEM_STAT_EN defined, stat_reads and stat_writes SHALL each increment by 1 in the DONE cycle of a completed read or write, respectively, saturating at 16'hFFFF.
REQ-031 Without SLOWMEM_STAT_EN, stat_reads and stat_writes SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-032 Port 0 writes 128'hDEADBEEF at address 5, then reads address 5 -> ready pulses 10 cycles after each grant, and rdata[0] = 128'hDEADBEEF.
REQ-033 Ports 0 and 1 request simultaneously after reset -> port 0 is served first and port 1 is granted at grant0+12, with each ready exactly one cycle wide.
REQ-034 Port 1 writes address 0x405 (DEPTH_LOG2=10), then reads address 5 -> the written data is returned.
REQ-035 rst is raised 4 cycles after a write grant -> no ready pulse, and a later read of that address returns the prior contents.
REQ-036 A request is dropped one cycle after grant -> the ready pulse still occurs at LATENCY and the write is committed.
REQ-037 With SLOWMEM_STAT_EN, 3 reads and 2 writes -> stat_reads=3 and stat_writes=2; without the macro, both read 0.
